id_ex_pipe_reg: RTL

Parametrised ID/EX pipeline register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush and bubble insertion. It sits between the decode stage (register file read, sign-extend, control unit) and the execute stage (ALU, branch/jump resolution). Generalises the fixed-width ID/EX latch: adds backpressure, flush, valid-gated control bits and a bubble counter.

---
 rtl/id_ex_pipe_reg_pkg.sv | 37 +++
 rtl/id_ex_pipe_reg_if.sv | 48 ++++
 rtl/id_ex_pipe_reg_skid.sv | 101 ++++++++++
 rtl/id_ex_pipe_reg.sv | 97 +++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pkg
// Description : Shared constants for the ID/EX pipeline register: ctrl field
//               layout, regs field offsets and handshake state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

   localparam int ALUOP_W = 6;
   localparam int CTRL_W  = 8 + ALUOP_W;

   // ctrl = {branch, jump, AluSrc, AluOp, MemRead, MemWrite, RegWrite, RegDst, MemtoReg}
   localparam int CTRL_BRANCH    = 13;
   localparam int CTRL_JUMP      = 12;
   localparam int CTRL_ALUSRC    = 11;
   localparam int CTRL_ALUOP_LSB = 5;
   localparam int CTRL_MEMREAD   = 4;
   localparam int CTRL_MEMWRITE  = 3;
   localparam int CTRL_REGWRITE  = 2;
   localparam int CTRL_REGDST    = 1;
   localparam int CTRL_MEMTOREG  = 0;

   localparam int REG_ADDR_W  = 5;
   localparam int REGS_W      = 3 * REG_ADDR_W;
   localparam int REGS_RS_LSB = 10;
   localparam int REGS_RT_LSB = 5;
   localparam int REGS_RD_LSB = 0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg_if
// Description : Decode-side and execute-side bundle of the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_ex_pipe_reg_if #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 6,
   parameter int CNT_W   = 16
);
   localparam int c_CTRL_W = 8 + ALUOP_W;
   localparam int c_REGS_W = 15;

   logic                flush;
   logic                in_valid;
   logic                in_ready;
   logic [c_CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0]   npc;
   logic [DATA_W-1:0]   readdata1;
   logic [DATA_W-1:0]   readdata2;
   logic [DATA_W-1:0]   sigext;
   logic [c_REGS_W-1:0] regs;
   logic                out_valid;
   logic                out_ready;
   logic [c_CTRL_W-1:0] ctrl_out;
   logic [DATA_W-1:0]   npc_out;
   logic [DATA_W-1:0]   readdata1_out;
   logic [DATA_W-1:0]   readdata2_out;
   logic [DATA_W-1:0]   sigext_out;
   logic [c_REGS_W-1:0] regs_out;
   logic                hazard_stall;
   logic [CNT_W-1:0]    bubble_cnt;

   modport master (
      output flush, in_valid, ctrl, npc, readdata1, readdata2, sigext, regs, out_ready,
      input  in_ready, out_valid, ctrl_out, npc_out, readdata1_out, readdata2_out,
             sigext_out, regs_out, hazard_stall, bubble_cnt
   );

   modport slave (
      input  flush, in_valid, ctrl, npc, readdata1, readdata2, sigext, regs, out_ready,
      output in_ready, out_valid, ctrl_out, npc_out, readdata1_out, readdata2_out,
             sigext_out, regs_out, hazard_stall, bubble_cnt
   );

endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_reg_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Generic W-bit two-entry valid/ready skid register with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
   import id_ex_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   pipe_state_t  r_state;
   pipe_state_t  w_state_nxt;
   logic [W-1:0] r_main;
   logic [W-1:0] r_skid;
   logic         w_accept;
   logic         w_consume;
   logic         w_load_main;
   logic         w_load_skid;
   logic         w_pop_skid;

   // in_ready is a pure decode of the state register, so it never sees out_ready
   assign in_ready  = (r_state != SKID);
   assign out_valid = (r_state != EMPTY);
   assign out_data  = r_main;
   assign w_accept  = in_valid && in_ready;
   assign w_consume = out_valid && out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_pop_skid  = 1'b0;
      if (flush) begin
         w_state_nxt = EMPTY;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_load_main = 1'b1;
                  w_state_nxt = FULL;
               end
            end
            FULL: begin
               if (w_accept && w_consume) begin
                  w_load_main = 1'b1;
               end else if (w_accept) begin
                  w_load_skid = 1'b1;
                  w_state_nxt = SKID;
               end else if (w_consume) begin
                  w_state_nxt = EMPTY;
               end
            end
            SKID: begin
               if (w_consume) begin
                  w_pop_skid  = 1'b1;
                  w_state_nxt = FULL;
               end
            end
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main) begin
            r_main <= in_data;
         end else if (w_pop_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= in_data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID/EX pipeline register with skid buffer, flush, bubble gating
//               and bubble counter. Load-use stall built when ID_EX_HAZARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
   parameter int DATA_W  = 32,
   parameter int ALUOP_W = 6,
   parameter int CNT_W   = 16
) (
   input logic             clk,
   input logic             rst,
   id_ex_pipe_reg_if.slave bus
);
   import id_ex_pkg::*;

   localparam int c_CTRL_W = 8 + ALUOP_W;
   localparam int c_W      = c_CTRL_W + 4 * DATA_W + REGS_W;
   localparam int c_BRANCH = c_CTRL_W - 1;
   localparam int c_JUMP   = c_CTRL_W - 2;

   logic                w_hazard;
   logic                w_in_valid;
   logic                w_skid_in_ready;
   logic                w_out_valid;
   logic [c_W-1:0]      w_in_data;
   logic [c_W-1:0]      w_out_data;
   logic [c_CTRL_W-1:0] w_ctrl_q;
   logic [c_CTRL_W-1:0] w_ctrl_gated;
   logic [CNT_W-1:0]    r_bubble_cnt;

   assign w_in_data = {bus.ctrl, bus.npc, bus.readdata1, bus.readdata2, bus.sigext, bus.regs};
   assign {w_ctrl_q, bus.npc_out, bus.readdata1_out, bus.readdata2_out,
           bus.sigext_out, bus.regs_out} = w_out_data;

`ifdef ID_EX_HAZARD_EN
   logic [REG_ADDR_W-1:0] w_rt_out;
   logic [REG_ADDR_W-1:0] w_rs_in;
   logic [REG_ADDR_W-1:0] w_rt_in;

   assign w_rt_out = bus.regs_out[REGS_RT_LSB +: REG_ADDR_W];
   assign w_rs_in  = bus.regs[REGS_RS_LSB +: REG_ADDR_W];
   assign w_rt_in  = bus.regs[REGS_RT_LSB +: REG_ADDR_W];
   // A load in EX whose destination feeds the decoding instruction; flush wins
   assign w_hazard = !bus.flush && bus.in_valid && w_out_valid &&
                     w_ctrl_q[CTRL_MEMREAD] && w_ctrl_q[CTRL_REGWRITE] &&
                     (w_rt_out != '0) && ((w_rt_out == w_rs_in) || (w_rt_out == w_rt_in));
`else
   assign w_hazard = 1'b0;
`endif

   assign w_in_valid       = bus.in_valid && !w_hazard;
   assign bus.in_ready     = w_skid_in_ready && !w_hazard;
   assign bus.out_valid    = w_out_valid;
   assign bus.hazard_stall = w_hazard;
   assign bus.bubble_cnt   = r_bubble_cnt;

   pipe_skid_reg #(
      .W (c_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .in_valid  (w_in_valid),
      .in_ready  (w_skid_in_ready),
      .in_data   (w_in_data),
      .out_valid (w_out_valid),
      .out_ready (bus.out_ready),
      .out_data  (w_out_data)
   );

   // Bits with side effects must read as a NOP while EX holds a bubble
   always_comb begin
      w_ctrl_gated = w_ctrl_q;
      if (!w_out_valid) begin
         w_ctrl_gated[c_BRANCH]      = 1'b0;
         w_ctrl_gated[c_JUMP]        = 1'b0;
         w_ctrl_gated[CTRL_MEMREAD]  = 1'b0;
         w_ctrl_gated[CTRL_MEMWRITE] = 1'b0;
         w_ctrl_gated[CTRL_REGWRITE] = 1'b0;
      end
   end

   assign bus.ctrl_out = w_ctrl_gated;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bubble_cnt <= '0;
      end else if (bus.out_ready && !w_out_valid && (r_bubble_cnt != '1)) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire
